ca_stream_engine: RTL and testbench

Parametrised streaming engine that computes one generation of a Life-like cellular automaton over a BOARD_W x BOARD_H board. Cells enter in raster order on a valid/ready stream and next-state cells leave in raster order on a second valid/ready stream. The birth/survive rule is run-time programmable. Sits between board storage (frame buffer/BRAM reader) and the board writer/renderer. Successor to the fixed-size, fixed-rule, no-backpressure Life pipeline.

---
 rtl/ca_stream_engine.sv | 181 ++++++++++++++++++
 tb/tb_ca_stream_engine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ca_stream_engine.sv
// Streams one generation of a Life-like cellular automaton over a BOARD_W x BOARD_H raster board.
// Define CA_POPULATION_EN to build the per-frame live-cell counter behind population_out.
module ca_stream_engine #(
    parameter int BOARD_W = 64,
    parameter int BOARD_H = 64,
    parameter int GEN_W   = 16
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  start_in,
    input  logic                                  update_in,
    input  logic [8:0]                            rule_birth_in,
    input  logic [8:0]                            rule_survive_in,
    input  logic                                  s_valid_in,
    output logic                                  s_ready_out,
    input  logic                                  s_alive_in,
    output logic                                  m_valid_out,
    input  logic                                  m_ready_in,
    output logic                                  m_alive_out,
    output logic [$clog2(BOARD_W)-1:0]            m_x_out,
    output logic [$clog2(BOARD_H)-1:0]            m_y_out,
    output logic                                  busy_out,
    output logic                                  done_out,
    output logic [GEN_W-1:0]                      gen_count_out,
    output logic [$clog2(BOARD_W*BOARD_H+1)-1:0]  population_out
);
    localparam int XW    = $clog2(BOARD_W);
    localparam int YW    = $clog2(BOARD_H);
    localparam int CELLS = BOARD_W * BOARD_H;
    localparam int CW    = $clog2(CELLS);
    localparam int FW    = $clog2(BOARD_W + 2);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_nxt;

    logic [8:0]         birth_q, survive_q;
    logic               update_q;
    logic [CW-1:0]      in_cnt;
    logic [XW-1:0]      ix;
    logic [FW-1:0]      fill;
    logic [XW-1:0]      ox;
    logic [YW-1:0]      oy;
    logic               all_produced;
    logic [BOARD_W-1:0] lb1, lb2;
    // The window's right column is never stored: it is the column entering this advance.
    // Bit 0 = row above centre, bit 1 = centre row, bit 2 = row below.
    logic [2:0]         win_l, win_c, col_new;

    logic       start_ok, out_free, advance, in_fire, produce, out_fire, last_out, cell_in;
    logic       lft_ok, rgt_ok, top_ok, bot_ok, alive_nxt;
    logic [3:0] n;

    always_comb begin
        start_ok    = (state == IDLE) && start_in;
        out_free    = !m_valid_out || m_ready_in;
        s_ready_out = (state == RUN) && out_free;
        advance     = ((state == RUN && s_valid_in) || (state == FLUSH && !all_produced)) && out_free;
        in_fire     = advance && (state == RUN);
        produce     = advance && (fill == FW'(BOARD_W + 1));
        out_fire    = m_valid_out && m_ready_in;
        last_out    = out_fire && (m_x_out == XW'(BOARD_W - 1)) && (m_y_out == YW'(BOARD_H - 1));
        cell_in     = (state == RUN) ? s_alive_in : 1'b0;
        col_new     = {cell_in, lb1[ix], lb2[ix]};
    end

    // Board edges are dead: mask by the coordinates of the cell being produced.
    always_comb begin
        lft_ok    = (ox != '0);
        rgt_ok    = (ox != XW'(BOARD_W - 1));
        top_ok    = (oy != '0);
        bot_ok    = (oy != YW'(BOARD_H - 1));
        n         = 4'(win_l[0] & lft_ok & top_ok) + 4'(win_l[1] & lft_ok) + 4'(win_l[2] & lft_ok & bot_ok)
                  + 4'(win_c[0] & top_ok) + 4'(win_c[2] & bot_ok)
                  + 4'(col_new[0] & rgt_ok & top_ok) + 4'(col_new[1] & rgt_ok)
                  + 4'(col_new[2] & rgt_ok & bot_ok);
        alive_nxt = update_q ? (win_c[1] ? survive_q[n] : birth_q[n]) : win_c[1];
    end

    always_comb begin
        state_nxt = state;
        busy_out  = (state != IDLE);
        done_out  = (state == DONE);
        case (state)
            IDLE:    if (start_in) state_nxt = RUN;
            RUN:     if (in_fire && in_cnt == CW'(CELLS - 1)) state_nxt = FLUSH;
            FLUSH:   if (last_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            birth_q      <= '0;
            survive_q    <= '0;
            update_q     <= 1'b0;
            in_cnt       <= '0;
            ix           <= '0;
            fill         <= '0;
            ox           <= '0;
            oy           <= '0;
            all_produced <= 1'b0;
            lb1          <= '0;
            lb2          <= '0;
            win_l        <= '0;
            win_c        <= '0;
        end else if (start_ok) begin
            birth_q      <= rule_birth_in;
            survive_q    <= rule_survive_in;
            update_q     <= update_in;
            in_cnt       <= '0;
            ix           <= '0;
            fill         <= '0;
            ox           <= '0;
            oy           <= '0;
            all_produced <= 1'b0;
        end else if (advance) begin
            lb1[ix] <= cell_in;
            lb2[ix] <= lb1[ix];
            win_l   <= win_c;
            win_c   <= col_new;
            ix      <= (ix == XW'(BOARD_W - 1)) ? '0 : ix + 1'b1;
            if (in_fire) in_cnt <= in_cnt + 1'b1;
            if (!produce) fill <= fill + 1'b1;
            if (produce) begin
                if (ox == XW'(BOARD_W - 1)) begin
                    ox <= '0;
                    oy <= oy + 1'b1;
                    if (oy == YW'(BOARD_H - 1)) all_produced <= 1'b1;
                end else begin
                    ox <= ox + 1'b1;
                end
            end
        end
    end

    // Output register holds its contents until the consumer takes them.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            m_valid_out <= 1'b0;
            m_alive_out <= 1'b0;
            m_x_out     <= '0;
            m_y_out     <= '0;
        end else if (produce) begin
            m_valid_out <= 1'b1;
            m_alive_out <= alive_nxt;
            m_x_out     <= ox;
            m_y_out     <= oy;
        end else if (out_fire) begin
            m_valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)              gen_count_out <= '0;
        else if (state == DONE)  gen_count_out <= gen_count_out + 1'b1;
    end

`ifdef CA_POPULATION_EN
    logic [$bits(population_out)-1:0] pop_acc;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pop_acc        <= '0;
            population_out <= '0;
        end else begin
            if (start_ok)                      pop_acc <= '0;
            else if (out_fire && m_alive_out)  pop_acc <= pop_acc + 1'b1;
            if (state == DONE)                 population_out <= pop_acc;
        end
    end
`else
    assign population_out = '0;
`endif

endmodule

// File: tb/tb_ca_stream_engine.sv
// Directed bench for ca_stream_engine on an 8x6 board: Life patterns, pass-through, HighLife,
// backpressure with input gaps, mid-frame reset and ignored restarts.
module tb_ca_stream_engine;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        update = 1'b0;
    logic [8:0]  rule_birth = '0;
    logic [8:0]  rule_survive = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_alive = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_alive;
    logic [2:0]  m_x, m_y;
    logic        busy, done;
    logic [15:0] gen;
    logic [5:0]  pop;

    int          total = 0;
    int          bad = 0;
    logic [N-1:0] cur, outb, expb, hand;
    logic [15:0] gen_exp = '0;

    ca_stream_engine #(.BOARD_W(W), .BOARD_H(H), .GEN_W(16)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .update_in(update),
        .rule_birth_in(rule_birth), .rule_survive_in(rule_survive),
        .s_valid_in(s_valid), .s_ready_out(s_ready), .s_alive_in(s_alive),
        .m_valid_out(m_valid), .m_ready_in(m_ready), .m_alive_out(m_alive),
        .m_x_out(m_x), .m_y_out(m_y), .busy_out(busy), .done_out(done),
        .gen_count_out(gen), .population_out(pop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [N-1:0] b, input logic upd,
                                           input logic [8:0] br, input logic [8:0] sv);
        logic [N-1:0] r;
        int cnt;
        r = '0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
                            cnt += int'(b[(y + dy) * W + x + dx]);
                r[y * W + x] = !upd ? b[y * W + x] : (b[y * W + x] ? sv[cnt] : br[cnt]);
            end
        return r;
    endfunction

    task automatic run_frame(input logic upd, input logic [8:0] br, input logic [8:0] sv,
                             input bit gaps, input bit restart);
        int in_i, out_i, cyc;
        bit seen_done, stall;
        logic pa;
        logic [2:0] px, py;
        expb = model(cur, upd, br, sv);
        outb = '0;
        @(negedge clk);
        start = 1'b1; update = upd; rule_birth = br; rule_survive = sv;
        @(negedge clk);
        // Scramble the rule after start: the engine must keep the latched copy.
        start = 1'b0; update = ~upd; rule_birth = ~br; rule_survive = ~sv;
        in_i = 0; out_i = 0; cyc = 0; seen_done = 0; stall = 0; pa = 0; px = 0; py = 0;
        while (!seen_done && cyc < 4000) begin
            s_valid = (in_i < N) && (!gaps || $urandom_range(0, 2) != 0);
            s_alive = (in_i < N) ? cur[in_i] : 1'b0;
            m_ready = !gaps || ($urandom_range(0, 1) == 1);
            start   = restart && (cyc == 30);
            #1;
            if (start) check("busy_at_restart", 64'(busy), 64'(1));
            if (stall) begin
                check("stall_valid", 64'(m_valid), 64'(1));
                check("stall_alive", 64'(m_alive), 64'(pa));
                check("stall_x", 64'(m_x), 64'(px));
                check("stall_y", 64'(m_y), 64'(py));
            end
            if (m_valid && !m_ready) check("s_ready_stalled", 64'(s_ready), 64'(0));
            if (s_valid && s_ready) in_i++;
            if (m_valid && m_ready) begin
                check("out_x", 64'(m_x), 64'(out_i % W));
                check("out_y", 64'(m_y), 64'(out_i / W));
                if (out_i < N) check("out_alive", 64'(m_alive), 64'(expb[out_i]));
                if (out_i < N) outb[out_i] = m_alive;
                out_i++;
            end
            stall = m_valid && !m_ready;
            pa = m_alive; px = m_x; py = m_y;
            if (done) seen_done = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", 64'(seen_done), 64'(1));
        check("handshakes", 64'(out_i), 64'(N));
        check("frame", 64'(outb), 64'(expb));
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b0; start = 1'b0;
        #1;
        check("done_pulse", 64'(done), 64'(0));
        check("busy_idle", 64'(busy), 64'(0));
        gen_exp++;
        check("gen_count", 64'(gen), 64'(gen_exp));
`ifdef CA_POPULATION_EN
        check("population", 64'(pop), 64'($countones(expb)));
`else
        check("population", 64'(pop), 64'(0));
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_gen", 64'(gen), 64'(0));
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_pop", 64'(pop), 64'(0));
        rst = 1'b0;

        // Blinker, horizontal at row 3 -> vertical at column 3
        cur = '0; cur[26] = 1; cur[27] = 1; cur[28] = 1;
        run_frame(1'b1, 9'h008, 9'h00C, 1'b0, 1'b0);
        hand = '0; hand[19] = 1; hand[27] = 1; hand[35] = 1;
        check("blinker_hand", 64'(outb), 64'(hand));

        // Corner L -> block, no wrap-around births
        cur = '0; cur[0] = 1; cur[1] = 1; cur[8] = 1;
        run_frame(1'b1, 9'h008, 9'h00C, 1'b0, 1'b0);
        hand = '0; hand[0] = 1; hand[1] = 1; hand[8] = 1; hand[9] = 1;
        check("corner_hand", 64'(outb), 64'(hand));

        // Pass-through of a random board
        cur = N'({$urandom(), $urandom()});
        run_frame(1'b0, 9'h008, 9'h00C, 1'b0, 1'b0);
        check("passthru", 64'(outb), 64'(cur));

        // Six neighbours around (3,2): HighLife births, Conway does not
        cur = '0; cur[10] = 1; cur[11] = 1; cur[12] = 1; cur[26] = 1; cur[27] = 1; cur[28] = 1;
        run_frame(1'b1, 9'h048, 9'h00C, 1'b0, 1'b0);
        check("highlife_birth", 64'(outb[19]), 64'(1));
        run_frame(1'b1, 9'h008, 9'h00C, 1'b0, 1'b0);
        check("conway_no_birth", 64'(outb[19]), 64'(0));

        // Random board under backpressure and input gaps, with an ignored restart
        cur = N'({$urandom(), $urandom()});
        run_frame(1'b1, 9'h008, 9'h00C, 1'b1, 1'b1);

        // Mid-frame asynchronous reset after 20 inputs
        cur = N'({$urandom(), $urandom()});
        @(negedge clk);
        start = 1'b1; update = 1'b1; rule_birth = 9'h008; rule_survive = 9'h00C; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1; s_alive = cur[i];
            @(negedge clk);
        end
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_m_valid", 64'(m_valid), 64'(0));
        check("mid_rst_m_xy", 64'({m_x, m_y, m_alive}), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_s_ready", 64'(s_ready), 64'(0));
        check("mid_rst_gen", 64'(gen), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        gen_exp = '0;
        @(negedge clk);
        rst = 1'b0; m_ready = 1'b0;
        cur = N'({$urandom(), $urandom()});
        run_frame(1'b1, 9'h008, 9'h00C, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
